// File: rtl/krnl_rtl_trial_a_example_axis_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : krnl_rtl_trial_a_example_axis_arbiter
// Purpose  : Packet-level round-robin arbiter merging C_NUM_SRC AXI4-Stream
//            sources onto a single registered output stream. A grant is held
//            for a whole packet (until the tlast beat is accepted).
// Ports    : aclk, aresetn (synchronous, active-low)
//            ctrl_enable            - permits new packet grants
//            s_axis_* [C_NUM_SRC]   - source streams, source i in slice i
//            m_axis_*               - merged output stream, m_axis_tid = source
//            busy                   - 1 while a packet grant is held
//            pkt_count              - packets completed on the output
// Revision : 1.0 - initial release
// ============================================================================
module krnl_rtl_trial_a_example_axis_arbiter #(
  parameter int C_NUM_SRC          = 2,
  parameter int C_AXIS_TDATA_WIDTH = 512
) (
  input  logic                                      aclk,
  input  logic                                      aresetn,
  input  logic                                      ctrl_enable,
  input  logic [C_NUM_SRC-1:0]                      s_axis_tvalid,
  output logic [C_NUM_SRC-1:0]                      s_axis_tready,
  input  logic [C_NUM_SRC*C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_NUM_SRC*C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_NUM_SRC-1:0]                      s_axis_tlast,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]             m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]           m_axis_tkeep,
  output logic                                      m_axis_tlast,
  output logic [1:0]                                m_axis_tid,
  output logic                                      busy,
  output logic [31:0]                               pkt_count
);

  localparam int C_KEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                    r_state;
  logic [1:0]                r_grant;
  logic [1:0]                r_last_grant;
  logic [31:0]               r_pkt_count;

  logic                      w_found;
  logic [1:0]                w_pick;
  logic [2:0]                w_cand;
  logic                      w_sel_valid;
  logic [C_AXIS_TDATA_WIDTH-1:0] w_sel_data;
  logic [C_KEEP_WIDTH-1:0]   w_sel_keep;
  logic                      w_sel_last;
  logic                      w_out_free;
  logic                      w_accept;

  // Round-robin search: candidates last_grant+1, +2, ... wrapping modulo
  // C_NUM_SRC. The 3-bit sum never exceeds 7, and one subtraction brings it
  // back into range because last_grant is always below C_NUM_SRC.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 1; k <= C_NUM_SRC; k++) begin
      w_cand = {1'b0, r_last_grant} + 3'(k);
      if (w_cand >= 3'(C_NUM_SRC)) begin
        w_cand = w_cand - 3'(C_NUM_SRC);
      end
      for (int i = 0; i < C_NUM_SRC; i++) begin
        if (!w_found && (w_cand == 3'(i)) && s_axis_tvalid[i]) begin
          w_found = 1'b1;
          w_pick  = 2'(i);
        end
      end
    end
  end

  // Select the granted source's beat.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    w_sel_keep  = '0;
    w_sel_last  = 1'b0;
    for (int i = 0; i < C_NUM_SRC; i++) begin
      if (r_grant == 2'(i)) begin
        w_sel_valid = s_axis_tvalid[i];
        w_sel_data  = s_axis_tdata[i*C_AXIS_TDATA_WIDTH +: C_AXIS_TDATA_WIDTH];
        w_sel_keep  = s_axis_tkeep[i*C_KEEP_WIDTH +: C_KEEP_WIDTH];
        w_sel_last  = s_axis_tlast[i];
      end
    end
  end

  // The single output register can take a new beat when empty or draining.
  assign w_out_free = ~m_axis_tvalid | m_axis_tready;
  assign w_accept   = (r_state == ST_GRANT) & w_sel_valid & w_out_free;

  generate
    for (genvar gi = 0; gi < C_NUM_SRC; gi++) begin : g_ready
      assign s_axis_tready[gi] = (r_state == ST_GRANT) && (r_grant == 2'(gi)) && w_out_free;
    end
  endgenerate

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_last_grant  <= 2'(C_NUM_SRC - 1);
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      r_pkt_count   <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        if (ctrl_enable && w_found) begin
          r_grant      <= w_pick;
          r_last_grant <= w_pick;
          r_state      <= ST_GRANT;
        end
      end else begin
        // ctrl_enable is ignored here: an open packet always runs to tlast.
        if (w_accept && w_sel_last) begin
          r_state <= ST_IDLE;
        end
      end

      if (w_accept) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= w_sel_data;
        m_axis_tkeep  <= w_sel_keep;
        m_axis_tlast  <= w_sel_last;
        m_axis_tid    <= r_grant;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        r_pkt_count <= r_pkt_count + 32'd1;
      end
    end
  end

  assign busy      = (r_state == ST_GRANT);
  assign pkt_count = r_pkt_count;

endmodule
`default_nettype wire

// File: doc/krnl_rtl_trial_a_example_axis_arbiter.md
KRNL_RTL_TRIAL_A_EXAMPLE_AXIS_ARBITER -- requirements
Module: krnl_rtl_trial_a_example_axis_arbiter

Interface
REQ-001 Parameters SHALL be:
- C_NUM_SRC, 2: number of AXI4-Stream sources; legal 2..4.
- C_AXIS_TDATA_WIDTH, 512: tdata width per source and on the output; multiple of 32.
REQ-002 Ports SHALL be (clock and reset first):
- aclk  in  1  single clock for all logic.
- aresetn  in  1  synchronous reset, active-low; one clock, synchronous active-low reset.
- ctrl_enable  in  1  when 1, new packet grants are permitted.
- s_axis_tvalid  in  C_NUM_SRC  per-source valid.
- s_axis_tready  out  C_NUM_SRC  per-source ready.
- s_axis_tdata  in  C_NUM_SRC*C_AXIS_TDATA_WIDTH  source i occupies slice i.
- s_axis_tkeep  in  C_NUM_SRC*C_AXIS_TDATA_WIDTH/8  per-source keep.
- s_axis_tlast  in  C_NUM_SRC  per-source last.
- m_axis_tvalid  out  1  output valid, to adder input.
- m_axis_tready  in  1  output ready.
- m_axis_tdata  out  C_AXIS_TDATA_WIDTH  output data.
- m_axis_tkeep  out  C_AXIS_TDATA_WIDTH/8  output keep.
- m_axis_tlast  out  1  output last.
- m_axis_tid  out  2  index of the source that produced the beat.
- busy  out  1  1 while in GRANT state.
- pkt_count  out  32  packets completed on the output.

Function
REQ-003 The FSM SHALL have two states, IDLE and GRANT, plus a 2-bit grant register and a 2-bit last_grant register.
REQ-004 In IDLE with ctrl_enable=1 and any s_axis_tvalid bit set, the block SHALL select the first requesting source searching upward from (last_grant+1) mod C_NUM_SRC, load it into grant and last_grant, and enter GRANT on the next cycle.
REQ-005 In IDLE with ctrl_enable=0 or no request, the state SHALL remain IDLE.
REQ-006 All s_axis_tready bits SHALL be 0 in IDLE.
REQ-007 In GRANT, s_axis_tready[grant] SHALL equal (~m_axis_tvalid | m_axis_tready); all other bits SHALL be 0.
REQ-008 A source beat SHALL be accepted when s_axis_tvalid[grant] and s_axis_tready[grant] are both 1. The accepted tdata, tkeep and tlast, with m_axis_tid=grant, SHALL be registered into the output stage, giving a latency of 1 cycle.
REQ-009 The output stage SHALL be a single register:
- Set m_axis_tvalid on accept.
- Clear it when m_axis_tready=1 and no accept occurs in that cycle.
- Hold data stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-010 Acceptance of a beat with tlast=1 SHALL return the FSM to IDLE. This gives exactly one arbitration bubble cycle between packets.
REQ-011 Deasserting ctrl_enable during GRANT SHALL NOT abort the current packet; it only blocks the next grant.
REQ-012 Zero-length packets do not exist; every packet is at least one beat, terminated by tlast.
REQ-013 busy SHALL be 1 exactly when the state is GRANT.
REQ-014 pkt_count SHALL increment by 1 on each cycle with m_axis_tvalid & m_axis_tready & m_axis_tlast, wrapping from 0xFFFFFFFF to 0.
REQ-015 A source that deasserts tvalid mid-packet SHALL keep the grant; no other source is served until its tlast beat is accepted.
REQ-016 Unused upper bits of m_axis_tid SHALL be 0.

Reset
REQ-017 While aresetn=0 at a rising aclk edge, the block SHALL set:
- state=IDLE, grant=0, last_grant=C_NUM_SRC-1;
- m_axis_tvalid=0, m_axis_tlast=0, m_axis_tid=0, m_axis_tdata=0, m_axis_tkeep=0;
- busy=0, pkt_count=0, s_axis_tready=0.
REQ-018 A reset asserted mid-packet SHALL discard the partial packet and the output register. After release, the first grant SHALL go to the lowest-index requester (source 0 if requesting).

Verification
REQ-019 Scenario 1: C_NUM_SRC=2; both sources valid continuously, each sending 3-beat packets; m_axis_tready=1. Required:
- grants alternate 0,1,0,1;
- one idle bubble between packets;
- after 4 packets, pkt_count=4.
REQ-020 Scenario 2: only source 1 requests, sending a 1-beat packet with tdata=0x0000002A. Required:
- s_axis_tready[1] rises 1 cycle after tvalid;
- m_axis_tvalid rises 1 cycle after accept, with tid=1 and tdata=0x2A.
REQ-021 Scenario 3: m_axis_tready=0 for 5 cycles mid-packet. Required:
- output beat held unchanged;
- s_axis_tready[grant]=0 during the stall;
- no beat lost or duplicated; per-packet beat count matches the input.
REQ-022 Scenario 4: ctrl_enable dropped during beat 2 of a 4-beat packet. Required:
- all 4 beats delivered;
- FSM returns to IDLE and stays there while other sources are valid;
- grants resume 1 cycle after ctrl_enable=1.
REQ-023 Scenario 5: aresetn pulsed low for 1 cycle mid-packet from source 1. Required:
- m_axis_tvalid=0 and pkt_count=0 next cycle;
- with both sources requesting, the first post-reset grant goes to source 0.
REQ-024 Scenario 6: pkt_count preloaded via forced sim state to 0xFFFFFFFF, then one packet completes. Required: pkt_count=0.
